toggle_stim_gen: RTL and testbench

- Synthesizable dual-channel square-wave source that drives the `a` and `b` inputs of the `inv` block.
- Each channel toggles every programmed number of clock cycles.
- A run is started by a pulse and lasts a fixed number of cycles. The block then freezes its outputs and flags completion.
- Sits directly upstream of `inv`: `a_out` feeds `inv.a`, `b_out` feeds `inv.b`.

---
 rtl/toggle_stim_gen_pkg.sv | 19 +
 rtl/toggle_stim_gen_half_period_toggler.sv | 56 +++++
 rtl/toggle_stim_gen.sv | 155 +++++++++++++++
 tb/tb_toggle_stim_gen.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/toggle_stim_gen_pkg.sv
// ---------------------------------------------------------------------------
// toggle_stim_gen_pkg
//   Shared definitions for the toggle stimulus generator:
//     - state_e   : FSM state encoding (IDLE / RUN / DONE), also the value
//                   presented on the debug state output.
//     - CNT_W_DEF : default width of the run and channel counters.
// ---------------------------------------------------------------------------
package toggle_stim_gen_pkg;

  // Encodings are fixed so the debug state output can be decoded by checkers.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int CNT_W_DEF = 16;

endpackage : toggle_stim_gen_pkg

// File: rtl/toggle_stim_gen_half_period_toggler.sv
// ---------------------------------------------------------------------------
// half_period_toggler
//   One square-wave channel. An internal W-bit counter advances on every
//   enabled cycle; when it reaches HALF-1 the output flips and the counter
//   restarts at 0, so the output toggles every HALF enabled cycles.
//
// Parameters
//   W     counter width
//   HALF  enabled cycles between output toggles (1..2^W-1)
//   INIT  reset / load level of q
//
// Ports
//   clk   clock, rising edge
//   rst   asynchronous active-high reset (q=INIT, count=0)
//   load  forces q=INIT and clears the count; has priority over en
//   en    advances the count by one cycle
//   q     channel output, driven straight from a flop
// ---------------------------------------------------------------------------
module half_period_toggler #(
  parameter int   W    = 16,
  parameter int   HALF = 100,
  parameter logic INIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic q
);

  // Terminal count evaluated at W bits; the counter never passes it.
  localparam logic [W-1:0] LP_TERM = W'(HALF - 1);

  logic [W-1:0] r_cnt;
  logic         r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_q   <= INIT;
    end else if (load) begin
      r_cnt <= '0;
      r_q   <= INIT;
    end else if (en) begin
      if (r_cnt == LP_TERM) begin
        r_cnt <= '0;
        r_q   <= ~r_q;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign q = r_q;

endmodule : half_period_toggler

// File: rtl/toggle_stim_gen.sv
// ---------------------------------------------------------------------------
// toggle_stim_gen
//   Dual-channel square-wave source feeding the a/b inputs of the inv block.
//   A start pulse launches a run of RUN_LEN cycles during which channel A
//   toggles every A_HALF cycles and channel B every B_HALF cycles. At the end
//   of the run the outputs freeze and done is raised; stop aborts a run and
//   returns the outputs to their idle levels.
//
// Parameters
//   CNT_W    width of all counters and of cycle_cnt
//   A_HALF   cycles between a_out toggles (1..2^CNT_W-1)
//   B_HALF   cycles between b_out toggles (1..2^CNT_W-1)
//   RUN_LEN  RUN cycles per run (1..2^CNT_W-1)
//   A_INIT   idle / reset level of a_out
//   B_INIT   idle / reset level of b_out
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   start      run request, sampled in IDLE and DONE
//   stop       abort request, sampled in RUN only
//   a_out      channel A waveform (to inv.a)
//   b_out      channel B waveform (to inv.b)
//   busy       high while in RUN
//   done       high while in DONE
//   cycle_cnt  RUN cycles elapsed in the current or last run
//   dbg_state  current FSM state (state_e encoding)
//
// Handshake: start and stop are level-sampled single-cycle requests with no
// acknowledge; a request is acted on at the next rising edge if the FSM is in
// a state that samples it, and is otherwise dropped without side effects.
// ---------------------------------------------------------------------------
module toggle_stim_gen
  import toggle_stim_gen_pkg::*;
#(
  parameter int   CNT_W   = CNT_W_DEF,
  parameter int   A_HALF  = 100,
  parameter int   B_HALF  = 50,
  parameter int   RUN_LEN = 1000,
  parameter logic A_INIT  = 1'b0,
  parameter logic B_INIT  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  output logic             a_out,
  output logic             b_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [1:0]       dbg_state
);

  // Last cycle_cnt value of a run; the counter holds here instead of wrapping.
  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(RUN_LEN - 1);

  state_e           r_state;
  logic             r_busy;
  logic             r_done;
  logic [CNT_W-1:0] r_cycle_cnt;

  logic w_in_run;
  logic w_load;
  logic w_en;

  assign w_in_run = (r_state == ST_RUN);

  // Channels reload their INIT level when a run starts (start in IDLE/DONE)
  // and when a run is aborted (stop in RUN). They only advance in RUN cycles
  // that are not being aborted; in DONE they simply hold, which freezes the
  // outputs at whatever level the final RUN edge produced.
  assign w_load = w_in_run ? stop : start;
  assign w_en   = w_in_run & ~stop;

  // -------------------------------------------------------------------------
  // FSM and run counter. busy/done are registered alongside the state from
  // the same next-state decision, so they change on the same edge as the
  // state with no extra latency.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_cycle_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state     <= ST_RUN;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_cycle_cnt <= '0;
          end
        end

        ST_RUN: begin
          if (stop) begin
            // Abort wins over a coincident terminal count; cycle_cnt is
            // kept so the abort point can be inspected.
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
          end else if (r_cycle_cnt == LP_LAST) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_cycle_cnt <= r_cycle_cnt + 1'b1;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Channel generators
  // -------------------------------------------------------------------------
  half_period_toggler #(
    .W    (CNT_W),
    .HALF (A_HALF),
    .INIT (A_INIT)
  ) u_chan_a (
    .clk  (clk),
    .rst  (rst),
    .load (w_load),
    .en   (w_en),
    .q    (a_out)
  );

  half_period_toggler #(
    .W    (CNT_W),
    .HALF (B_HALF),
    .INIT (B_INIT)
  ) u_chan_b (
    .clk  (clk),
    .rst  (rst),
    .load (w_load),
    .en   (w_en),
    .q    (b_out)
  );

  assign busy      = r_busy;
  assign done      = r_done;
  assign cycle_cnt = r_cycle_cnt;
  assign dbg_state = r_state;

endmodule : toggle_stim_gen

// File: tb/tb_toggle_stim_gen.sv
// ---------------------------------------------------------------------------
// tb_toggle_stim_gen
//   Two instances: u_def with default parameters and u_sht with
//   A_HALF=1, B_HALF=3, RUN_LEN=7. Expected output words are
//   {state[1:0], a, b, busy, done, cycle_cnt[15:0]}, derived in closed form
//   from the number of rising edges seen since the start pulse.
// ---------------------------------------------------------------------------
module tb_toggle_stim_gen;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        start_d, stop_d, a_d, b_d, busy_d, done_d;
  logic [15:0] cnt_d;
  logic [1:0]  st_d;
  logic        start_s, stop_s, a_s, b_s, busy_s, done_s;
  logic [15:0] cnt_s;
  logic [1:0]  st_s;

  toggle_stim_gen u_def (
    .clk       (clk),
    .rst       (rst),
    .start     (start_d),
    .stop      (stop_d),
    .a_out     (a_d),
    .b_out     (b_d),
    .busy      (busy_d),
    .done      (done_d),
    .cycle_cnt (cnt_d),
    .dbg_state (st_d)
  );

  toggle_stim_gen #(
    .CNT_W   (16),
    .A_HALF  (1),
    .B_HALF  (3),
    .RUN_LEN (7),
    .A_INIT  (1'b0),
    .B_INIT  (1'b1)
  ) u_sht (
    .clk       (clk),
    .rst       (rst),
    .start     (start_s),
    .stop      (stop_s),
    .a_out     (a_s),
    .b_out     (b_s),
    .busy      (busy_s),
    .done      (done_s),
    .cycle_cnt (cnt_s),
    .dbg_state (st_s)
  );

  // ---------------- scoreboard ----------------
  logic [21:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  // Expected word k rising edges after the start pulse was sampled
  // (k=0 is the first RUN cycle).
  function automatic logic [21:0] exp_word(int k, int ah, int bh, int rl);
    int   kk;
    logic a, b, in_run;
    logic [15:0] c;
    in_run = (k < rl);
    kk = in_run ? k : rl;
    a  = 1'b0 ^ (((kk / ah) % 2) == 1);
    b  = 1'b1 ^ (((kk / bh) % 2) == 1);
    c  = in_run ? 16'(k) : 16'(rl - 1);
    return {(in_run ? 2'd1 : 2'd2), a, b, in_run, ~in_run, c};
  endfunction

  function automatic logic [21:0] idle_word(logic [15:0] c);
    return {2'd0, 1'b0, 1'b1, 1'b0, 1'b0, c};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [21:0] got, e;
    rst = 1'b1;
    start_d = 1'b0; stop_d = 1'b0; start_s = 1'b0; stop_s = 1'b0;
    repeat (3) tick();
    exp_q.push_back(idle_word(16'd0));
    exp_q.push_back(idle_word(16'd0));
    got = {st_d, a_d, b_d, busy_d, done_d, cnt_d};
    e = exp_q.pop_front();
    n_checks++;
    if (got !== e) $display("FAIL reset_def: got=%h expected=%h", got, e); else n_pass++;
    got = {st_s, a_s, b_s, busy_s, done_s, cnt_s};
    e = exp_q.pop_front();
    n_checks++;
    if (got !== e) $display("FAIL reset_sht: got=%h expected=%h", got, e); else n_pass++;
    rst = 1'b0;
    // start is low: both stay idle after release
    exp_q.push_back(idle_word(16'd0));
    tick();
    got = {st_d, a_d, b_d, busy_d, done_d, cnt_d};
    e = exp_q.pop_front();
    n_checks++;
    if (got !== e) $display("FAIL reset_release: got=%h expected=%h", got, e); else n_pass++;
  endtask

  task automatic test_full_run();
    logic [21:0] got, e;
    start_d = 1'b1;
    exp_q.push_back(exp_word(0, 100, 50, 1000));
    tick();
    start_d = 1'b0;
    got = {st_d, a_d, b_d, busy_d, done_d, cnt_d};
    e = exp_q.pop_front();
    n_checks++;
    if (got !== e) $display("FAIL start_busy: got=%h expected=%h", got, e); else n_pass++;
    // k up to 1005 covers DONE being held after the run
    for (int k = 1; k <= 1005; k++) begin
      exp_q.push_back(exp_word(k, 100, 50, 1000));
      tick();
      got = {st_d, a_d, b_d, busy_d, done_d, cnt_d};
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e) $display("FAIL full_run k=%0d: got=%h expected=%h", k, got, e); else n_pass++;
    end
  endtask

  task automatic test_stop();
    logic [21:0] got, e;
    start_d = 1'b1;
    exp_q.push_back(exp_word(0, 100, 50, 1000));
    tick();
    start_d = 1'b0;
    for (int k = 0; k <= 430; k++) begin
      if (k > 0) begin
        exp_q.push_back(exp_word(k, 100, 50, 1000));
        tick();
      end
      got = {st_d, a_d, b_d, busy_d, done_d, cnt_d};
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e) $display("FAIL stop_run k=%0d: got=%h expected=%h", k, got, e); else n_pass++;
    end
    // abort at RUN cycle 430, then keep stop high in IDLE (ignored)
    stop_d = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(idle_word(16'd430));
      tick();
      got = {st_d, a_d, b_d, busy_d, done_d, cnt_d};
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e) $display("FAIL stop_abort i=%0d: got=%h expected=%h", i, got, e); else n_pass++;
    end
    stop_d = 1'b0;
    // restart: cycle_cnt begins again at 0
    start_d = 1'b1;
    for (int k = 0; k <= 5; k++) begin
      exp_q.push_back(exp_word(k, 100, 50, 1000));
      tick();
      start_d = 1'b0;
      got = {st_d, a_d, b_d, busy_d, done_d, cnt_d};
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e) $display("FAIL stop_restart k=%0d: got=%h expected=%h", k, got, e); else n_pass++;
    end
    stop_d = 1'b1;
    exp_q.push_back(idle_word(16'd5));
    tick();
    stop_d = 1'b0;
    got = {st_d, a_d, b_d, busy_d, done_d, cnt_d};
    e = exp_q.pop_front();
    n_checks++;
    if (got !== e) $display("FAIL stop_abort2: got=%h expected=%h", got, e); else n_pass++;
  endtask

  task automatic test_async_reset();
    logic [21:0] got, e;
    start_d = 1'b1;
    for (int k = 0; k <= 275; k++) begin
      exp_q.push_back(exp_word(k, 100, 50, 1000));
      tick();
      start_d = 1'b0;
      got = {st_d, a_d, b_d, busy_d, done_d, cnt_d};
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e) $display("FAIL areset_run k=%0d: got=%h expected=%h", k, got, e); else n_pass++;
    end
    // assert reset between edges and look before any clock edge
    #2;
    rst = 1'b1;
    exp_q.push_back(idle_word(16'd0));
    #1;
    got = {st_d, a_d, b_d, busy_d, done_d, cnt_d};
    e = exp_q.pop_front();
    n_checks++;
    if (got !== e) $display("FAIL areset_immediate: got=%h expected=%h", got, e); else n_pass++;
    rst = 1'b0;
    exp_q.push_back(idle_word(16'd0));
    tick();
    got = {st_d, a_d, b_d, busy_d, done_d, cnt_d};
    e = exp_q.pop_front();
    n_checks++;
    if (got !== e) $display("FAIL areset_idle: got=%h expected=%h", got, e); else n_pass++;
    // fresh run after release
    start_d = 1'b1;
    for (int k = 0; k <= 60; k++) begin
      exp_q.push_back(exp_word(k, 100, 50, 1000));
      tick();
      start_d = 1'b0;
      got = {st_d, a_d, b_d, busy_d, done_d, cnt_d};
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e) $display("FAIL areset_fresh k=%0d: got=%h expected=%h", k, got, e); else n_pass++;
    end
    stop_d = 1'b1;
    exp_q.push_back(idle_word(16'd60));
    tick();
    stop_d = 1'b0;
    got = {st_d, a_d, b_d, busy_d, done_d, cnt_d};
    e = exp_q.pop_front();
    n_checks++;
    if (got !== e) $display("FAIL areset_stop: got=%h expected=%h", got, e); else n_pass++;
  endtask

  task automatic test_short_run();
    logic [21:0] got, e;
    start_s = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      exp_q.push_back(exp_word(k, 1, 3, 7));
      tick();
      start_s = 1'b0;
      got = {st_s, a_s, b_s, busy_s, done_s, cnt_s};
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e) $display("FAIL short_run k=%0d: got=%h expected=%h", k, got, e); else n_pass++;
    end
    // explicit end-of-run levels: 7 toggles of a from 0, 2 toggles of b from 1
    n_checks++;
    if ({a_s, b_s, done_s} !== 3'b111) $display("FAIL short_final: got=%b expected=111", {a_s, b_s, done_s});
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [21:0] got, e;
    // start held through RUN is ignored; released before the final edge
    start_s = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      if (k == 6) start_s = 1'b0;
      if (k == 8) stop_s = 1'b1;
      exp_q.push_back(exp_word(k, 1, 3, 7));
      tick();
      got = {st_s, a_s, b_s, busy_s, done_s, cnt_s};
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e) $display("FAIL hold_start k=%0d: got=%h expected=%h", k, got, e); else n_pass++;
    end
    stop_s = 1'b0;
    // stop on the terminal cycle aborts instead of finishing
    start_s = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      exp_q.push_back(exp_word(k, 1, 3, 7));
      tick();
      start_s = 1'b0;
      got = {st_s, a_s, b_s, busy_s, done_s, cnt_s};
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e) $display("FAIL term_run k=%0d: got=%h expected=%h", k, got, e); else n_pass++;
    end
    stop_s = 1'b1;
    exp_q.push_back(idle_word(16'd6));
    tick();
    got = {st_s, a_s, b_s, busy_s, done_s, cnt_s};
    e = exp_q.pop_front();
    n_checks++;
    if (got !== e) $display("FAIL term_abort: got=%h expected=%h", got, e); else n_pass++;
    // start together with stop in IDLE: start wins
    start_s = 1'b1;
    exp_q.push_back(exp_word(0, 1, 3, 7));
    tick();
    start_s = 1'b0;
    stop_s  = 1'b0;
    got = {st_s, a_s, b_s, busy_s, done_s, cnt_s};
    e = exp_q.pop_front();
    n_checks++;
    if (got !== e) $display("FAIL start_stop_idle: got=%h expected=%h", got, e); else n_pass++;
    for (int k = 1; k <= 8; k++) begin
      exp_q.push_back(exp_word(k, 1, 3, 7));
      tick();
      got = {st_s, a_s, b_s, busy_s, done_s, cnt_s};
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e) $display("FAIL restart_run k=%0d: got=%h expected=%h", k, got, e); else n_pass++;
    end
    // default instance has been idle (left there by the last abort) throughout
    exp_q.push_back(idle_word(16'd60));
    got = {st_d, a_d, b_d, busy_d, done_d, cnt_d};
    e = exp_q.pop_front();
    n_checks++;
    if (got !== e) $display("FAIL def_undisturbed: got=%h expected=%h", got, e); else n_pass++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_full_run();
    test_stop();
    test_async_reset();
    test_short_run();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "timeout");
  end

endmodule : tb_toggle_stim_gen
